fp_adder_operand_master: RTL and testbench
==========================================

// Module: fp_adder_operand_master
// PURPOSE
//  Initiator side of the FP adder store/acknowledge handshake. Accepts an
//  operand-pair job, drives A then B into the adder, and collects SUM. It then
//  returns the result plus a tag to the issuing controller (e.g. the Halley sqrt
//  sequencer). A per-job watchdog aborts a stalled transaction and returns quiet NaN.
// PARAMETERS
//  TAG_W           4    width of the job tag carried through to the result
//  TIMEOUT_CYCLES  256  max cycles spent in SEND_A+SEND_B+WAIT_SUM before abort (>=2)
// PORTS
//  Clock              in   1       rising-edge clock; sole clock domain
//  Reset              in   1       synchronous, active-low reset (0 = reset)
//  Job_valid          in   1       job offered
//  Job_ready          out  1       job accepted when Job_valid & Job_ready at edge
//  Job_A, Job_B       in   64      IEEE-754 double operands
//  Job_subtract       in   1       1: compute A-B (flip B[63] before sending)
//  Job_tag            in   TAG_W   opaque tag echoed with result
//  A, B               out  64      operand buses to adder
//  A_store_bit        out  1       A valid; transfer when A_store_bit & A_acknowledgment
//  B_store_bit        out  1       B valid; transfer when B_store_bit & B_acknowledgment
//  A_acknowledgment   in   1       adder ready for A
//  B_acknowledgment   in   1       adder ready for B
//  SUM                in   64      adder result
//  SUM_store_bit      in   1       SUM valid
//  SUM_acknowledgment out  1       ready for SUM; transfer when both high at edge
//  Result_valid       out  1       result held for controller
//  Result_ready       in   1       controller accepts result
//  Result             out  64      captured SUM, or 64'hFFF8000000000000 on timeout
//  Result_tag         out  TAG_W   tag of the job
//  Result_timeout     out  1       1 = job aborted by watchdog
// BEHAVIOUR
//  - Reset (Reset==0 at edge): state IDLE; every output 0; watchdog cleared.
//  - FSM: IDLE -> SEND_A -> SEND_B -> WAIT_SUM -> DELIVER -> IDLE.
//  - IDLE: Job_ready=1 (only here). On accept: latch A=Job_A,
//    B={Job_B[63]^Job_subtract,Job_B[62:0]}, tag; next cycle A_store_bit=1.
//  - SEND_A: A_store_bit held 1, A stable until transfer edge; at that edge
//    A_store_bit<=0, B_store_bit<=1, state SEND_B. No combinational ack->store path.
//  - SEND_B: same rule for B; on transfer B_store_bit<=0, SUM_acknowledgment<=1.
//  - WAIT_SUM: SUM_acknowledgment=1; on SUM_store_bit&SUM_acknowledgment capture
//    SUM into Result, Result_timeout=0, SUM_acknowledgment<=0, Result_valid<=1.
//  - DELIVER: Result_valid, Result, Result_tag, Result_timeout stable until
//    Result_ready; on that edge Result_valid<=0, state IDLE. Result_ready
//    outside DELIVER ignored.
//  - Min latency: accept at edge N, A xfer N+1, B xfer N+2, SUM xfer N+3,
//    Result_valid high from N+4 (zero-wait adder).
//  - Watchdog: counter cleared on job accept, +1 each cycle in SEND_A/SEND_B/
//    WAIT_SUM; when count==TIMEOUT_CYCLES-1 and no transfer that edge: drop
//    all store bits and SUM_acknowledgment, Result=64'hFFF8000000000000,
//    Result_timeout=1, go DELIVER. A transfer on the same edge wins over timeout.
//  - Counter saturates; never wraps. Width = $clog2(TIMEOUT_CYCLES)+1.
//  - Reset mid-transaction: immediate return to IDLE, outputs 0; the adder is
//    expected to be reset by the same Reset net.
//  - SUM_store_bit/acks outside their states ignored; no state change.
// STRUCTURE
//  - fp_pkg: FP_QNAN = 64'hFFF8000000000000, FP_SIGN_BIT = 63, state enum
//    fp_master_state_t {IDLE,SEND_A,SEND_B,WAIT_SUM,DELIVER}.
//  - Sub-module hs_watchdog (clear, enable, limit -> expired) holds the counter;
//    FSM and datapath registers stay in this module. All flops in one
//    always_ff per concern; no latches.
// TESTING
//  1. Add: Job_A=3FF0000000000000, Job_B=4000000000000000, tag=5; model returns
//     SUM=4008000000000000 -> Result=4008000000000000, tag=5, timeout=0, Result_valid at N+4.
//  2. Subtract: Job_A=4008000000000000, Job_B=3FF0000000000000, Job_subtract=1 ->
//     B bus=BFF0000000000000 at B transfer.
//  3. Backpressure: A_acknowledgment low 10 cycles -> A_store_bit stays 1, A stable,
//     Job_ready=0 throughout; proceeds on 11th cycle.
//  4. Timeout: TIMEOUT_CYCLES=16, model never raises B_acknowledgment ->
//     Result=FFF8000000000000, Result_timeout=1, B_store_bit=0 after 16 cycles.
//  5. Result stall: Result_ready low 5 cycles -> Result/tag stable, Job_ready=0;
//     second job accepted only after Result_ready; back-to-back jobs keep tags in order.
//  6. Reset asserted in WAIT_SUM -> next edge all outputs 0, state IDLE, Job_ready=1
//     after Reset released.

Source files
------------

// File: rtl/fp_adder_operand_master_pkg.sv
// Shared constants, state encoding and helpers for the FP adder operand master.
package fp_adder_operand_master_pkg;

  localparam logic [63:0] FP_QNAN = 64'hFFF8_0000_0000_0000;
  localparam int unsigned FP_SIGN_BIT = 63;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_SUM,
    DELIVER
  } fp_master_state_t;

  // Conditionally negate an IEEE-754 double by toggling its sign bit.
  function automatic logic [63:0] fp_flip_sign(input logic [63:0] x, input logic flip);
    logic [63:0] r;
    r = x;
    r[FP_SIGN_BIT] = x[FP_SIGN_BIT] ^ flip;
    return r;
  endfunction

endpackage

// File: rtl/fp_adder_operand_master_if.sv
// Job, adder-operand and result signals of the FP adder operand master.
// master: the operand master itself; slave: the controller/adder environment.
interface fp_adder_operand_master_if #(
  parameter int unsigned TAG_W = 4
) ();

  logic             job_valid;
  logic             job_ready;
  logic [63:0]      job_a;
  logic [63:0]      job_b;
  logic             job_subtract;
  logic [TAG_W-1:0] job_tag;

  logic [63:0]      a;
  logic [63:0]      b;
  logic             a_store_bit;
  logic             b_store_bit;
  logic             a_acknowledgment;
  logic             b_acknowledgment;
  logic [63:0]      sum;
  logic             sum_store_bit;
  logic             sum_acknowledgment;

  logic             result_valid;
  logic             result_ready;
  logic [63:0]      result;
  logic [TAG_W-1:0] result_tag;
  logic             result_timeout;

  modport master (
    input  job_valid, job_a, job_b, job_subtract, job_tag,
    input  a_acknowledgment, b_acknowledgment, sum, sum_store_bit, result_ready,
    output job_ready, a, b, a_store_bit, b_store_bit, sum_acknowledgment,
    output result_valid, result, result_tag, result_timeout
  );

  modport slave (
    output job_valid, job_a, job_b, job_subtract, job_tag,
    output a_acknowledgment, b_acknowledgment, sum, sum_store_bit, result_ready,
    input  job_ready, a, b, a_store_bit, b_store_bit, sum_acknowledgment,
    input  result_valid, result, result_tag, result_timeout
  );

endinterface

// File: rtl/fp_adder_operand_master_hs_watchdog.sv
// Per-job cycle counter; flags the last permitted cycle of a transaction.
module fp_adder_operand_master_hs_watchdog #(
  parameter int unsigned CntW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [CntW-1:0] limit,
  output logic            expired
);

  logic [CntW-1:0] count_q;

  // Clear has priority; the count saturates at limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != limit)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // Not gated by enable so the owning FSM can use it without a combinational loop.
  assign expired = (count_q == (limit - CntW'(1)));

endmodule

// File: rtl/fp_adder_operand_master.sv
// Initiator of the FP adder store/acknowledge handshake: sends A then B, collects
// SUM and hands the result plus tag back to the controller. Stalls are aborted
// by a watchdog that returns a quiet NaN.
module fp_adder_operand_master
  import fp_adder_operand_master_pkg::*;
#(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                        clk,
  input logic                        rst_n,
  fp_adder_operand_master_if.master  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  fp_master_state_t state_q, state_d;
  logic [63:0]      a_q, a_d, b_q, b_d, result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             a_stb_q, a_stb_d, b_stb_q, b_stb_d, sum_ack_q, sum_ack_d;
  logic             rv_q, rv_d, tmo_q, tmo_d, job_ready_q, job_ready_d;
  logic             wd_clear, wd_enable, wd_expired, abort;

  fp_adder_operand_master_hs_watchdog #(
    .CntW (CntW)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (CntW'(TIMEOUT_CYCLES)),
    .expired (wd_expired)
  );

  // Next-state and registered-output decode; a transfer beats a same-edge timeout.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    a_stb_d   = a_stb_q;
    b_stb_d   = b_stb_q;
    sum_ack_d = sum_ack_q;
    rv_d      = rv_q;
    result_d  = result_q;
    tmo_d     = tmo_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          a_d      = bus.job_a;
          b_d      = fp_flip_sign(bus.job_b, bus.job_subtract);
          tag_d    = bus.job_tag;
          a_stb_d  = 1'b1;
          wd_clear = 1'b1;
          state_d  = SEND_A;
        end
      end
      SEND_A: begin
        wd_enable = 1'b1;
        if (a_stb_q && bus.a_acknowledgment) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = SEND_B;
        end else begin
          abort = wd_expired;
        end
      end
      SEND_B: begin
        wd_enable = 1'b1;
        if (b_stb_q && bus.b_acknowledgment) begin
          b_stb_d   = 1'b0;
          sum_ack_d = 1'b1;
          state_d   = WAIT_SUM;
        end else begin
          abort = wd_expired;
        end
      end
      WAIT_SUM: begin
        wd_enable = 1'b1;
        if (bus.sum_store_bit && sum_ack_q) begin
          result_d  = bus.sum;
          tmo_d     = 1'b0;
          sum_ack_d = 1'b0;
          rv_d      = 1'b1;
          state_d   = DELIVER;
        end else begin
          abort = wd_expired;
        end
      end
      DELIVER: begin
        if (bus.result_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      a_stb_d   = 1'b0;
      b_stb_d   = 1'b0;
      sum_ack_d = 1'b0;
      result_d  = FP_QNAN;
      tmo_d     = 1'b1;
      rv_d      = 1'b1;
      state_d   = DELIVER;
    end

    // Registered so that every output, including job_ready, reads 0 under reset.
    job_ready_d = (state_d == IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, result and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      sum_ack_q   <= 1'b0;
      rv_q        <= 1'b0;
      result_q    <= '0;
      tmo_q       <= 1'b0;
      job_ready_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      sum_ack_q   <= sum_ack_d;
      rv_q        <= rv_d;
      result_q    <= result_d;
      tmo_q       <= tmo_d;
      job_ready_q <= job_ready_d;
    end
  end

  assign bus.job_ready          = job_ready_q;
  assign bus.a                  = a_q;
  assign bus.b                  = b_q;
  assign bus.a_store_bit        = a_stb_q;
  assign bus.b_store_bit        = b_stb_q;
  assign bus.sum_acknowledgment = sum_ack_q;
  assign bus.result_valid       = rv_q;
  assign bus.result             = result_q;
  assign bus.result_tag         = tag_q;
  assign bus.result_timeout     = tmo_q;

endmodule

// File: tb/tb_fp_adder_operand_master.sv
// Bench for fp_adder_operand_master: directed and random jobs against a real-arithmetic
// reference, with an adder model whose acknowledge delays are set per job.
module tb_fp_adder_operand_master;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned TMO   = 16;
  localparam logic [63:0] QNAN  = 64'hFFF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fp_adder_operand_master_if #(.TAG_W(TAG_W)) bus ();

  fp_adder_operand_master #(
    .TAG_W          (TAG_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.job_valid        = 1'b0;
    bus.job_a            = '0;
    bus.job_b            = '0;
    bus.job_subtract     = 1'b0;
    bus.job_tag          = '0;
    bus.a_acknowledgment = 1'b0;
    bus.b_acknowledgment = 1'b0;
    bus.sum              = '0;
    bus.sum_store_bit    = 1'b0;
    bus.result_ready     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " job_ready"},      bus.job_ready, 0);
    check({tag, " a"},              bus.a, 0);
    check({tag, " b"},              bus.b, 0);
    check({tag, " a_store_bit"},    bus.a_store_bit, 0);
    check({tag, " b_store_bit"},    bus.b_store_bit, 0);
    check({tag, " sum_ack"},        bus.sum_acknowledgment, 0);
    check({tag, " result_valid"},   bus.result_valid, 0);
    check({tag, " result"},         bus.result, 0);
    check({tag, " result_tag"},     bus.result_tag, 0);
    check({tag, " result_timeout"}, bus.result_timeout, 0);
  endtask

  function automatic logic [63:0] rand_double();
    logic [63:0] r;
    r[63]    = 1'($urandom_range(0, 1));
    r[62:52] = 11'(1000 + $urandom_range(0, 46));
    r[51:32] = 20'($urandom);
    r[31:0]  = $urandom;
    return r;
  endfunction

  // Offer a job and wait for its accept edge; returns with job_valid dropped.
  task automatic accept_job(input logic [63:0] ja, input logic [63:0] jb, input logic sub,
                            input logic [TAG_W-1:0] tag);
    int guard;
    bus.job_valid    = 1'b1;
    bus.job_a        = ja;
    bus.job_b        = jb;
    bus.job_subtract = sub;
    bus.job_tag      = tag;
    guard = 0;
    while (!bus.job_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("job_ready before accept", bus.job_ready, 1);
    tick();
    bus.job_valid = 1'b0;
    check("a_store_bit after accept", bus.a_store_bit, 1);
    check("job_ready after accept", bus.job_ready, 0);
  endtask

  // aw/bw/sw: cycles the adder holds its side back; rw: cycles result_ready stays low.
  task automatic run_job(input logic [63:0] ja, input logic [63:0] jb, input logic sub,
                         input logic [TAG_W-1:0] tag, input int aw, input int bw,
                         input int sw, input int rw, input bit b_never);
    real         ra, rb;
    logic [63:0] exp_b, exp_res, a_cap, sum_val, held;
    bit          exp_tmo, done;
    int          exp_lat, lat, a_seen, b_seen, s_seen;

    ra      = $bitstoreal(ja);
    rb      = $bitstoreal(jb);
    if (sub) rb = -rb;
    exp_b   = $realtobits(rb);
    exp_tmo = b_never || (aw + bw + sw + 3 > int'(TMO));
    exp_res = exp_tmo ? QNAN : $realtobits(ra + rb);
    exp_lat = exp_tmo ? int'(TMO) : aw + bw + sw + 3;

    accept_job(ja, jb, sub, tag);
    lat = 0; a_seen = 0; b_seen = 0; s_seen = 0; done = 0;
    a_cap = '0; sum_val = '0;
    while (!done) begin
      bus.a_acknowledgment = bus.a_store_bit && (a_seen >= aw);
      bus.b_acknowledgment = bus.b_store_bit && !b_never && (b_seen >= bw);
      bus.sum_store_bit    = bus.sum_acknowledgment && (s_seen >= sw);
      bus.sum              = sum_val;
      if (bus.a_store_bit) begin
        check("a bus", bus.a, ja);
        if (bus.a_acknowledgment) a_cap = bus.a;
        a_seen++;
      end
      if (bus.b_store_bit) begin
        check("b bus", bus.b, exp_b);
        if (bus.b_acknowledgment)
          sum_val = $realtobits($bitstoreal(a_cap) + $bitstoreal(bus.b));
        b_seen++;
      end
      if (bus.sum_acknowledgment) s_seen++;
      check("job_ready while busy", bus.job_ready, 0);
      tick();
      lat++;
      if (bus.result_valid) begin
        done = 1;
      end else if (lat >= 60) begin
        check("result_valid within budget", bus.result_valid, 1);
        done = 1;
      end
    end
    bus.a_acknowledgment = 1'b0;
    bus.b_acknowledgment = 1'b0;
    bus.sum_store_bit    = 1'b0;

    check("latency", 64'(lat), 64'(exp_lat));
    check("result", bus.result, exp_res);
    check("result_tag", bus.result_tag, tag);
    check("result_timeout", bus.result_timeout, exp_tmo);
    check("a_store_bit at deliver", bus.a_store_bit, 0);
    check("b_store_bit at deliver", bus.b_store_bit, 0);
    check("sum_ack at deliver", bus.sum_acknowledgment, 0);

    held = bus.result;
    for (int i = 0; i < rw; i++) begin
      tick();
      check("stall result_valid", bus.result_valid, 1);
      check("stall result", bus.result, held);
      check("stall tag", bus.result_tag, tag);
      check("stall job_ready", bus.job_ready, 0);
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("result_valid after ready", bus.result_valid, 0);
    check("job_ready after deliver", bus.job_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int guard;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("job_ready after reset", bus.job_ready, 1);

    // Handshake inputs in IDLE must not move the FSM.
    bus.a_acknowledgment = 1'b1;
    bus.b_acknowledgment = 1'b1;
    bus.sum_store_bit    = 1'b1;
    bus.result_ready     = 1'b1;
    repeat (2) tick();
    drive_idle();
    check("idle stray a_store_bit", bus.a_store_bit, 0);
    check("idle stray sum_ack", bus.sum_acknowledgment, 0);
    check("idle stray result_valid", bus.result_valid, 0);
    check("idle stray job_ready", bus.job_ready, 1);

    // Add 1.0 + 2.0, zero-wait adder.
    run_job(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd5, 0, 0, 0, 0, 0);
    check("add result", bus.result, 64'h4008_0000_0000_0000);
    // Subtract 3.0 - 1.0; B goes out with its sign flipped.
    run_job(64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 4'd6, 0, 0, 0, 0, 0);
    check("sub result", bus.result, 64'h4000_0000_0000_0000);
    // A held back 10 cycles.
    run_job(64'h4010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b0, 4'd7, 10, 0, 0, 0, 0);
    // B never acknowledged: watchdog abort.
    run_job(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 4'd8, 0, 0, 0, 0, 1);
    // Transfer on the last permitted edge still wins.
    run_job(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd9, 5, 5, 3, 0, 0);
    // Result stall then back-to-back jobs keep their tags.
    run_job(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd1, 0, 0, 0, 5, 0);
    run_job(64'h4014_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 4'd2, 0, 1, 0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      run_job(rand_double(), rand_double(), 1'($urandom_range(0, 1)),
              TAG_W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    // Reset while waiting for SUM.
    accept_job(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd3);
    bus.a_acknowledgment = 1'b1;
    bus.b_acknowledgment = 1'b1;
    guard = 0;
    while (!bus.sum_acknowledgment && guard < 10) begin
      tick();
      guard++;
    end
    check("reached WAIT_SUM", bus.sum_acknowledgment, 1);
    drive_idle();
    rst_n = 1'b0;
    tick();
    check_all_zero("mid reset");
    rst_n = 1'b1;
    tick();
    check("job_ready after mid reset", bus.job_ready, 1);
    check("result_valid after mid reset", bus.result_valid, 0);
    run_job(64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 4'd4, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
